// File: rtl/tristate_buffer.sv
// WIDTH-bit tristate bus driver with a clocked bus-ownership status block (active flag, drive counter).
// Define TRISTATE_BUFFER_REGISTERED_OUTPUT_EN to register a/g ahead of the final driver stage.
module tristate_buffer #(
    parameter int WIDTH      = 8,
    parameter int PRIMITIVES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             g,
    output wire  [WIDTH-1:0] q,
    output logic             active,
    output logic [CNT_W-1:0] drive_cnt
);

    logic [WIDTH-1:0] drv_data;
    logic             drv_en;

`ifdef TRISTATE_BUFFER_REGISTERED_OUTPUT_EN
    logic [WIDTH-1:0] data_q;
    logic             en_q;

    // Reset clears the enable, so the bus is released without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            en_q   <= 1'b0;
        end else begin
            data_q <= a;
            en_q   <= g;
        end
    end

    assign drv_data = data_q;
    assign drv_en   = en_q;
`else
    assign drv_data = a;
    assign drv_en   = g;
`endif

    generate
        if (PRIMITIVES != 0) begin : g_prim
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                bufif1 u_buf (q[i], drv_data[i], drv_en);
            end
        end else begin : g_assign
            assign q = drv_en ? drv_data : {WIDTH{1'bz}};
        end
    endgenerate

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating count of edges on which this driver owned the bus.
    always_comb begin
        cnt_d = cnt_q;
        if (drv_en && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= drv_en;
            cnt_q    <= cnt_d;
        end
    end

    assign active    = active_q;
    assign drive_cnt = cnt_q;

endmodule

// File: tb/tb_tristate_buffer.sv
// Scoreboard bench for tristate_buffer: bus drive/release, status counter, reset and saturation.
`timescale 1ns/1ps
module tb_tristate_buffer;

`ifdef TRISTATE_BUFFER_REGISTERED_OUTPUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        g = 1'b0;
    logic        ext_en = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  ext_val = 8'h00;
    wire  [7:0]  q_p, q_a, q_s;
    logic        act_p, act_a, act_s;
    logic [15:0] cnt_p, cnt_a;
    logic [3:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Second bus driver: only shows through when the DUT has released the bus.
    assign q_p = ext_en ? ext_val : 8'bz;
    assign q_a = ext_en ? ext_val : 8'bz;

    tristate_buffer #(.WIDTH(8), .PRIMITIVES(1), .CNT_W(16)) u_prim (
        .clk(clk), .rst_n(rst_n), .a(a), .g(g), .q(q_p), .active(act_p), .drive_cnt(cnt_p));
    tristate_buffer #(.WIDTH(8), .PRIMITIVES(0), .CNT_W(16)) u_asgn (
        .clk(clk), .rst_n(rst_n), .a(a), .g(g), .q(q_a), .active(act_a), .drive_cnt(cnt_a));
    tristate_buffer #(.WIDTH(8), .PRIMITIVES(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .g(g), .q(q_s), .active(act_s), .drive_cnt(cnt_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endfunction

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got %h expected nothing queued", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    // Drive a/g; when g=0 the external driver puts ~a on the bus, which must read back clean.
    task automatic comb_step(input logic [7:0] av, input logic gv);
        logic [7:0] ev;
        a       = av;
        g       = gv;
        ext_en  = !gv;
        ext_val = ~av;
        ev      = gv ? av : ~av;
        push("q_prim", {24'h0, ev});
        push("q_assign", {24'h0, ev});
        #10;
        pop_chk({24'h0, q_p});
        pop_chk({24'h0, q_a});
    endtask

    initial begin
        #1;
        push("rst_active", 0);
        push("rst_cnt", 0);
        pop_chk({31'h0, act_p});
        pop_chk({16'h0, cnt_p});
`ifndef TRISTATE_BUFFER_REGISTERED_OUTPUT_EN
        a = 8'h3C; g = 1'b1;
        #10;
        push("rst_q_follows", 8'h3C);
        pop_chk({24'h0, q_p});
        push("rst_cnt_hold", 0);
        pop_chk({16'h0, cnt_p});
`endif
        g = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifndef TRISTATE_BUFFER_REGISTERED_OUTPUT_EN
        comb_step(8'b10101010, 1'b0);
        comb_step(8'b11001100, 1'b1);
        comb_step(8'b00001111, 1'b0);
        comb_step(8'b11110000, 1'b1);
`endif
        ext_en = 1'b0;

        // Counter: 5 enabled edges then 3 disabled edges.
        @(negedge clk);
        rst_n = 1'b0; #1; rst_n = 1'b1; g = 1'b1;
        repeat (5) @(negedge clk);
        push("cnt_after5", 5 - LAT);
        push("act_after5", 1);
        pop_chk({16'h0, cnt_p});
        pop_chk({31'h0, act_p});
        g = 1'b0;
        repeat (3) @(negedge clk);
        push("cnt_after8", 5);
        push("act_after8", 0);
        push("cnt_asgn_after8", 5);
        pop_chk({16'h0, cnt_p});
        pop_chk({31'h0, act_p});
        pop_chk({16'h0, cnt_a});

        // Reset mid-operation, between clock edges.
        rst_n = 1'b0; #1; rst_n = 1'b1; a = 8'h96; g = 1'b1;
        repeat (3) @(negedge clk);
        push("cnt_pre_rst", 3 - LAT);
        pop_chk({16'h0, cnt_p});
        #2;
`ifdef TRISTATE_BUFFER_REGISTERED_OUTPUT_EN
        ext_en = 1'b1; ext_val = 8'h69;
`endif
        rst_n = 1'b0;
        #1;
        push("midrst_active", 0);
        push("midrst_cnt", 0);
        pop_chk({31'h0, act_p});
        pop_chk({16'h0, cnt_p});
`ifdef TRISTATE_BUFFER_REGISTERED_OUTPUT_EN
        push("midrst_q_released", 8'h69);
        pop_chk({24'h0, q_p});
        ext_en = 1'b0;
`else
        push("midrst_q_prim", 8'h96);
        push("midrst_q_assign", 8'h96);
        pop_chk({24'h0, q_p});
        pop_chk({24'h0, q_a});
`endif

        // Saturation of the 4-bit counter.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        push("sat_cnt14", 14 - LAT);
        pop_chk({28'h0, cnt_s});
        repeat (2) @(negedge clk);
        push("sat_cnt16", 4'hF);
        pop_chk({28'h0, cnt_s});
        repeat (4) @(negedge clk);
        push("sat_cnt20", 4'hF);
        push("sat_active", 1);
        push("wide_cnt20", 20 - LAT);
        pop_chk({28'h0, cnt_s});
        pop_chk({31'h0, act_s});
        pop_chk({16'h0, cnt_p});

`ifdef TRISTATE_BUFFER_REGISTERED_OUTPUT_EN
        g = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h5A; g = 1'b1; ext_en = 1'b1; ext_val = 8'hA5;
        #1;
        push("reg_q_before_edge", 8'hA5);
        pop_chk({24'h0, q_p});
        @(posedge clk);
        ext_en = 1'b0;
        #1;
        push("reg_q_prim", 8'h5A);
        push("reg_q_assign", 8'h5A);
        pop_chk({24'h0, q_p});
        pop_chk({24'h0, q_a});
        ext_en = 1'b1;
        rst_n = 1'b0;
        #1;
        push("reg_q_rst_release", 8'hA5);
        pop_chk({24'h0, q_p});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
